cp0_vectored: RTL and testbench

CP0_VECTORED -- requirements
Module: cp0_vectored

---
 rtl/cp0_vectored.sv | 176 +++++++++++++++++
 tb/tb_cp0_vectored.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_vectored.sv
// CP0 subset with vectored interrupts: STATUS/CAUSE/EPC/EBASE, synchronized
// interrupt inputs, and a one-cycle force-jump pulse for interrupt entry and ERET.
module cp0_vectored #(
    parameter int          N_IRQ    = 4,
    parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       oper,
    input  logic [4:0]       addr_r,
    output logic [31:0]      data_r,
    input  logic [4:0]       addr_w,
    input  logic [31:0]      data_w,
    input  logic             ir_en,
    input  logic [N_IRQ-1:0] ir_in,
    input  logic [31:0]      ret_addr,
    output logic             jump_en,
    output logic [31:0]      jump_addr
);

    localparam logic [1:0] OP_MTC0 = 2'b10;
    localparam logic [1:0] OP_ERET = 2'b11;

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;
    localparam logic [4:0] REG_EBASE  = 5'd15;

    // The service state is the EXL bit itself.
    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic             ie_reg, ie_next;
    logic [N_IRQ-1:0] im_reg, im_next;
    logic [N_IRQ-1:0] ip_reg, ip_next;
    logic [2:0]       code_reg, code_next;
    logic [31:0]      epc_reg, epc_next;
    logic [31:0]      ebase_reg, ebase_next;
    logic             jump_en_reg, jump_en_next;
    logic [31:0]      jump_addr_reg, jump_addr_next;

    logic [N_IRQ-1:0] sync1_reg, sync2_reg, edge_reg;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] pend;
    logic [N_IRQ-1:0] sel_mask;
    logic [2:0]       sel_idx;
    logic             exl;
    logic             is_mtc0;
    logic             is_eret;
    logic             take;
    logic [31:0]      status_word;
    logic [31:0]      cause_word;

    assign exl     = (state_reg == SERVICE);
    assign is_mtc0 = (oper == OP_MTC0);
    assign is_eret = (oper == OP_ERET);

    generate
        for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_src
            assign rise[gi] = sync2_reg[gi] & ~edge_reg[gi];
            assign pend[gi] = ip_reg[gi] & im_reg[gi];
        end
    endgenerate

    // Lowest set bit wins: index 0 has the highest priority.
    assign sel_mask = pend & ~(pend - 1'b1);

    always_comb begin
        sel_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    // ERET suppresses take for the edge it occupies.
    assign take = ir_en & ie_reg & ~exl & (|pend) & ~is_eret;

    always_comb begin
        state_next     = state_reg;
        ie_next        = ie_reg;
        im_next        = im_reg;
        ip_next        = ip_reg;
        code_next      = code_reg;
        epc_next       = epc_reg;
        ebase_next     = ebase_reg;
        jump_en_next   = 1'b0;
        jump_addr_next = jump_addr_reg;

        if (is_mtc0) begin
            case (addr_w)
                REG_STATUS: begin
                    ie_next    = data_w[0];
                    state_next = data_w[1] ? SERVICE : IDLE;
                    im_next    = data_w[8 +: N_IRQ];
                end
                REG_CAUSE: ip_next    = ip_reg & ~data_w[8 +: N_IRQ];
                REG_EPC:   epc_next   = data_w;
                REG_EBASE: ebase_next = {data_w[31:2], 2'b00};
                default: ;
            endcase
        end

        if (is_eret) begin
            state_next     = IDLE;
            jump_en_next   = 1'b1;
            jump_addr_next = epc_reg;
        end else if (take) begin
            // Overrides any EXL value written by a coincident MTC0 STATUS.
            state_next     = SERVICE;
            epc_next       = ret_addr;
            code_next      = sel_idx;
            ip_next        = ip_next & ~sel_mask;
            jump_en_next   = 1'b1;
            jump_addr_next = ebase_reg + {26'd0, sel_idx, 3'b000};
        end

        // A fresh synchronized edge beats any clear of the same bit.
        ip_next = ip_next | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ie_reg        <= 1'b0;
            im_reg        <= '0;
            ip_reg        <= '0;
            code_reg      <= '0;
            epc_reg       <= '0;
            ebase_reg     <= VEC_BASE & 32'hFFFF_FFFC;
            jump_en_reg   <= 1'b0;
            jump_addr_reg <= '0;
            sync1_reg     <= '0;
            sync2_reg     <= '0;
            edge_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            ie_reg        <= ie_next;
            im_reg        <= im_next;
            ip_reg        <= ip_next;
            code_reg      <= code_next;
            epc_reg       <= epc_next;
            ebase_reg     <= ebase_next;
            jump_en_reg   <= jump_en_next;
            jump_addr_reg <= jump_addr_next;
            sync1_reg     <= ir_in;
            sync2_reg     <= sync1_reg;
            edge_reg      <= sync2_reg;
        end
    end

    always_comb begin
        status_word              = '0;
        status_word[0]           = ie_reg;
        status_word[1]           = exl;
        status_word[8 +: N_IRQ]  = im_reg;
        cause_word               = '0;
        cause_word[8 +: N_IRQ]   = ip_reg;
        cause_word[4:2]          = code_reg;
        case (addr_r)
            REG_STATUS: data_r = status_word;
            REG_CAUSE:  data_r = cause_word;
            REG_EPC:    data_r = epc_reg;
            REG_EBASE:  data_r = ebase_reg;
            default:    data_r = '0;
        endcase
    end

    assign jump_en   = jump_en_reg;
    assign jump_addr = jump_addr_reg;

endmodule

// File: tb/tb_cp0_vectored.sv
// Directed bench for cp0_vectored: each task drives one scenario and checks inline.
module tb_cp0_vectored;

    logic        clk;
    logic        rst;
    logic [1:0]  oper;
    logic [4:0]  addr_r;
    logic [31:0] data_r;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic        ir_en;
    logic [3:0]  ir_in;
    logic [31:0] ret_addr;
    logic        jump_en;
    logic [31:0] jump_addr;

    int checks   = 0;
    int failures = 0;

    cp0_vectored #(.N_IRQ(4), .VEC_BASE(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .oper(oper),
        .addr_r(addr_r), .data_r(data_r),
        .addr_w(addr_w), .data_w(data_w),
        .ir_en(ir_en), .ir_in(ir_in), .ret_addr(ret_addr),
        .jump_en(jump_en), .jump_addr(jump_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        addr_r = a;
        #1;
        v = data_r;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        oper = 2'b10; addr_w = a; data_w = d;
        tick();
        oper = 2'b00;
    endtask

    task automatic do_reset();
        oper = 2'b00; addr_w = '0; data_w = '0; addr_r = '0;
        ir_en = 1'b0; ir_in = '0; ret_addr = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        rd(5'd12, v); checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=%h", v, 32'h0); end
        rd(5'd13, v); checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL reset_cause got=%h exp=%h", v, 32'h0); end
        rd(5'd14, v); checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL reset_epc got=%h exp=%h", v, 32'h0); end
        rd(5'd15, v); checks++;
        if (v !== 32'h100) begin failures++; $display("FAIL reset_ebase got=%h exp=%h", v, 32'h100); end
        rd(5'd5, v); checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL reset_other_reg got=%h exp=%h", v, 32'h0); end
        checks++;
        if (jump_en !== 1'b0 || jump_addr !== 32'h0) begin
            failures++; $display("FAIL reset_jump got=%b/%h exp=0/00000000", jump_en, jump_addr);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_take();
        logic [31:0] v;
        do_reset();
        mtc0(5'd12, 32'h0000_0301);
        ir_en = 1'b1; ret_addr = 32'h40;
        ir_in[1] = 1'b1;
        tick(); tick();
        rd(5'd13, v); checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL basic_ip_early got=%h exp=%h", v, 32'h0); end
        tick();
        rd(5'd13, v); checks++;
        if (v !== 32'h200) begin failures++; $display("FAIL basic_ip_set got=%h exp=%h", v, 32'h200); end
        checks++;
        if (jump_en !== 1'b0) begin failures++; $display("FAIL basic_no_early_jump got=%b exp=0", jump_en); end
        tick();
        checks++;
        if (jump_en !== 1'b1 || jump_addr !== 32'h108) begin
            failures++; $display("FAIL basic_jump got=%b/%h exp=1/00000108", jump_en, jump_addr);
        end
        rd(5'd14, v); checks++;
        if (v !== 32'h40) begin failures++; $display("FAIL basic_epc got=%h exp=%h", v, 32'h40); end
        rd(5'd12, v); checks++;
        if (v !== 32'h303) begin failures++; $display("FAIL basic_status got=%h exp=%h", v, 32'h303); end
        rd(5'd13, v); checks++;
        if (v !== 32'h4) begin failures++; $display("FAIL basic_cause got=%h exp=%h", v, 32'h4); end
        tick();
        checks++;
        if (jump_en !== 1'b0 || jump_addr !== 32'h108) begin
            failures++; $display("FAIL basic_pulse_end got=%b/%h exp=0/00000108", jump_en, jump_addr);
        end
        $display("test_basic_take done");
    endtask

    task automatic test_priority_eret();
        logic [31:0] v;
        do_reset();
        mtc0(5'd12, 32'h0000_0501);
        ir_en = 1'b1; ret_addr = 32'h200;
        ir_in = 4'b0101;
        tick(); tick(); tick();
        rd(5'd13, v); checks++;
        if (v !== 32'h500) begin failures++; $display("FAIL prio_ip_both got=%h exp=%h", v, 32'h500); end
        tick();
        checks++;
        if (jump_en !== 1'b1 || jump_addr !== 32'h100) begin
            failures++; $display("FAIL prio_first_jump got=%b/%h exp=1/00000100", jump_en, jump_addr);
        end
        rd(5'd13, v); checks++;
        if (v !== 32'h400) begin failures++; $display("FAIL prio_cause_after got=%h exp=%h", v, 32'h400); end
        tick();
        checks++;
        if (jump_en !== 1'b0) begin failures++; $display("FAIL prio_no_nesting got=%b exp=0", jump_en); end
        ret_addr = 32'h300;
        oper = 2'b11;
        tick();
        oper = 2'b00;
        checks++;
        if (jump_en !== 1'b1 || jump_addr !== 32'h200) begin
            failures++; $display("FAIL eret_wins_jump got=%b/%h exp=1/00000200", jump_en, jump_addr);
        end
        rd(5'd12, v); checks++;
        if (v !== 32'h501) begin failures++; $display("FAIL eret_status got=%h exp=%h", v, 32'h501); end
        tick();
        checks++;
        if (jump_en !== 1'b1 || jump_addr !== 32'h110) begin
            failures++; $display("FAIL prio_second_jump got=%b/%h exp=1/00000110", jump_en, jump_addr);
        end
        rd(5'd13, v); checks++;
        if (v !== 32'h8) begin failures++; $display("FAIL prio_cause_code2 got=%h exp=%h", v, 32'h8); end
        rd(5'd14, v); checks++;
        if (v !== 32'h300) begin failures++; $display("FAIL prio_epc2 got=%h exp=%h", v, 32'h300); end
        $display("test_priority_eret done");
    endtask

    task automatic test_gating();
        logic [31:0] v;
        do_reset();
        mtc0(5'd12, 32'h0000_0400);
        ir_en = 1'b1;
        ir_in[2] = 1'b1;
        tick(); tick(); tick();
        rd(5'd13, v); checks++;
        if (v !== 32'h400) begin failures++; $display("FAIL gate_ip got=%h exp=%h", v, 32'h400); end
        tick();
        checks++;
        if (jump_en !== 1'b0) begin failures++; $display("FAIL gate_ie0 got=%b exp=0", jump_en); end
        ir_en = 1'b0;
        mtc0(5'd12, 32'h0000_0401);
        checks++;
        if (jump_en !== 1'b0) begin failures++; $display("FAIL gate_mtc0_edge got=%b exp=0", jump_en); end
        tick();
        checks++;
        if (jump_en !== 1'b0) begin failures++; $display("FAIL gate_ir_en0 got=%b exp=0", jump_en); end
        ir_en = 1'b1;
        tick();
        checks++;
        if (jump_en !== 1'b1 || jump_addr !== 32'h110) begin
            failures++; $display("FAIL gate_release got=%b/%h exp=1/00000110", jump_en, jump_addr);
        end
        $display("test_gating done");
    endtask

    task automatic test_masked_mfc0();
        logic [31:0] v;
        do_reset();
        mtc0(5'd12, 32'h0000_0001);
        ir_en = 1'b1;
        ir_in[0] = 1'b1;
        tick(); tick(); tick();
        oper = 2'b01;
        addr_r = 5'd12;
        tick();
        checks++;
        if (jump_en !== 1'b0) begin failures++; $display("FAIL masked_no_jump1 got=%b exp=0", jump_en); end
        tick();
        checks++;
        if (jump_en !== 1'b0) begin failures++; $display("FAIL masked_no_jump2 got=%b exp=0", jump_en); end
        oper = 2'b00;
        rd(5'd13, v); checks++;
        if (v !== 32'h100) begin failures++; $display("FAIL masked_pending got=%h exp=%h", v, 32'h100); end
        rd(5'd12, v); checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL mfc0_status got=%h exp=%h", v, 32'h1); end
        $display("test_masked_mfc0 done");
    endtask

    task automatic test_w1c();
        logic [31:0] v;
        do_reset();
        ir_in[1] = 1'b1;
        tick(); tick(); tick();
        oper = 2'b10; addr_w = 5'd13; data_w = 32'h0000_021C;
        rd(5'd13, v); checks++;
        if (v !== 32'h200) begin failures++; $display("FAIL w1c_read_old got=%h exp=%h", v, 32'h200); end
        tick();
        oper = 2'b00;
        rd(5'd13, v); checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL w1c_clear got=%h exp=%h", v, 32'h0); end
        ir_in[1] = 1'b0;
        tick(); tick(); tick();
        ir_in[1] = 1'b1;
        tick(); tick();
        mtc0(5'd13, 32'h0000_0200);
        rd(5'd13, v); checks++;
        if (v !== 32'h200) begin failures++; $display("FAIL w1c_set_wins got=%h exp=%h", v, 32'h200); end
        $display("test_w1c done");
    endtask

    task automatic test_take_vs_mtc0();
        logic [31:0] v;
        do_reset();
        mtc0(5'd12, 32'h0000_0101);
        ir_en = 1'b1;
        ir_in[0] = 1'b1;
        tick(); tick(); tick();
        mtc0(5'd12, 32'h0000_0201);
        checks++;
        if (jump_en !== 1'b1 || jump_addr !== 32'h100) begin
            failures++; $display("FAIL take_mtc0_jump got=%b/%h exp=1/00000100", jump_en, jump_addr);
        end
        rd(5'd12, v); checks++;
        if (v !== 32'h203) begin failures++; $display("FAIL take_mtc0_status got=%h exp=%h", v, 32'h203); end
        $display("test_take_vs_mtc0 done");
    endtask

    task automatic test_reset_service();
        logic [31:0] v;
        do_reset();
        mtc0(5'd12, 32'h0000_0101);
        ir_en = 1'b1; ret_addr = 32'h80;
        ir_in[0] = 1'b1;
        tick(); tick(); tick(); tick();
        rd(5'd14, v); checks++;
        if (jump_en !== 1'b1 || v !== 32'h80) begin
            failures++; $display("FAIL rsvc_take got=%b/%h exp=1/00000080", jump_en, v);
        end
        tick();
        mtc0(5'd15, 32'h0000_0203);
        rd(5'd15, v); checks++;
        if (v !== 32'h200) begin failures++; $display("FAIL rsvc_ebase_write got=%h exp=%h", v, 32'h200); end
        rd(5'd12, v); checks++;
        if (v !== 32'h103) begin failures++; $display("FAIL rsvc_in_service got=%h exp=%h", v, 32'h103); end
        rst = 1'b1; oper = 2'b11; ir_in = '0;
        tick();
        checks++;
        if (jump_en !== 1'b0 || jump_addr !== 32'h0) begin
            failures++; $display("FAIL rsvc_no_pulse got=%b/%h exp=0/00000000", jump_en, jump_addr);
        end
        rst = 1'b0; oper = 2'b00;
        rd(5'd12, v); checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL rsvc_status got=%h exp=%h", v, 32'h0); end
        rd(5'd13, v); checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL rsvc_cause got=%h exp=%h", v, 32'h0); end
        rd(5'd14, v); checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL rsvc_epc got=%h exp=%h", v, 32'h0); end
        rd(5'd15, v); checks++;
        if (v !== 32'h100) begin failures++; $display("FAIL rsvc_ebase got=%h exp=%h", v, 32'h100); end
        tick();
        checks++;
        if (jump_en !== 1'b0) begin failures++; $display("FAIL rsvc_after got=%b exp=0", jump_en); end
        $display("test_reset_service done");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic_take();
        test_priority_eret();
        test_gating();
        test_masked_mfc0();
        test_w1c();
        test_take_vs_mtc0();
        test_reset_service();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
